// File: rtl/hangman_game_ctrl.sv
// hangman_game_ctrl: game-state controller for the hangman VGA display.
// Holds a WORD_LEN-letter secret word and takes letter guesses over a
// valid/ready handshake. Each accepted guess is scanned against the word one
// slot per cycle. The block drives registered glyph codes, a wrong-guess count
// and win/lose flags.
// Optional feature macro: HANGMAN_REVEAL_ON_LOSS_EN. When it is defined, a lost
// game shows the true letters in the unrevealed slots. When it is undefined,
// those slots show 'X' (27).
module hangman_game_ctrl #(
  parameter int WORD_LEN  = 10,
  parameter int MAX_WRONG = 6
) (
  input  logic                    dclk,
  input  logic                    clr_n,
  input  logic                    start,
  input  logic [5*WORD_LEN-1:0]   word,
  input  logic                    guess_valid,
  input  logic [4:0]              guess_letter,
  output logic                    guess_ready,
  output logic                    guess_dup,
  output logic [5*WORD_LEN-1:0]   slot_code,
  output logic [2:0]              wrong_cnt,
  output logic                    game_won,
  output logic                    game_lost
);

  localparam int             IW          = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IW-1:0]  LAST_IDX    = IW'(WORD_LEN - 1);
  localparam logic [2:0]     WRONG_LIMIT = 3'(MAX_WRONG);
  localparam logic [4:0]     LAST_LETTER = 5'd25;
  localparam logic [4:0]     GLYPH_HIDE  = 5'd26;
  localparam logic [4:0]     GLYPH_X     = 5'd27;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PLAY   = 3'd1,
    SCAN   = 3'd2,
    UPDATE = 3'd3,
    WON    = 3'd4,
    LOST   = 3'd5
  } state_t;

  // Registered game state
  state_t                  state_r;
  logic [5*WORD_LEN-1:0]   word_r;
  logic [WORD_LEN-1:0]     reveal_r;
  logic [25:0]             guessed_r;
  logic [IW-1:0]           idx_r;
  logic [4:0]              letter_r;
  logic                    hit_r;

  // Next-state values
  state_t                  state_nx_s;
  logic [5*WORD_LEN-1:0]   word_nx_s;
  logic [WORD_LEN-1:0]     reveal_nx_s;
  logic [25:0]             guessed_nx_s;
  logic [2:0]              wrong_nx_s;
  logic [IW-1:0]           idx_nx_s;
  logic [4:0]              letter_nx_s;
  logic                    hit_nx_s;
  logic                    dup_nx_s;
  logic [2:0]              wrong_upd_s;

  // Letter code held in one slot of a packed word
  function automatic logic [4:0] slot_of(input logic [5*WORD_LEN-1:0] w,
                                         input logic [IW-1:0] idx);
    slot_of = w[int'(idx)*5 +: 5];
  endfunction

  // Slots holding a non-letter code need no guess and start out revealed
  function automatic logic [WORD_LEN-1:0] prereveal(input logic [5*WORD_LEN-1:0] w);
    logic [WORD_LEN-1:0] m;
    m = {WORD_LEN{1'b0}};
    for (int i = 0; i < WORD_LEN; i++) begin
      m[i] = (w[5*i +: 5] > LAST_LETTER);
    end
    prereveal = m;
  endfunction

  // Glyph row seen by the renderer for a given word, reveal mask and loss flag
  function automatic logic [5*WORD_LEN-1:0] glyphs(input logic [5*WORD_LEN-1:0] w,
                                                   input logic [WORD_LEN-1:0]   rv,
                                                   input logic                  lost);
    logic [5*WORD_LEN-1:0] g;
    g = {WORD_LEN{GLYPH_HIDE}};
    for (int i = 0; i < WORD_LEN; i++) begin
      if (rv[i]) begin
        g[5*i +: 5] = w[5*i +: 5];
      end else if (lost) begin
`ifdef HANGMAN_REVEAL_ON_LOSS_EN
        g[5*i +: 5] = w[5*i +: 5];
`else
        g[5*i +: 5] = GLYPH_X;
`endif
      end else begin
        g[5*i +: 5] = GLYPH_HIDE;
      end
    end
    glyphs = g;
  endfunction

  // Wrong count after a scan: bump on a miss, never beyond the limit
  assign wrong_upd_s = (hit_r || (wrong_cnt >= WRONG_LIMIT)) ? wrong_cnt
                                                             : wrong_cnt + 3'd1;

  // Next-state logic; start overrides everything, including a guess in flight
  always_comb begin
    state_nx_s   = state_r;
    word_nx_s    = word_r;
    reveal_nx_s  = reveal_r;
    guessed_nx_s = guessed_r;
    wrong_nx_s   = wrong_cnt;
    idx_nx_s     = idx_r;
    letter_nx_s  = letter_r;
    hit_nx_s     = hit_r;
    dup_nx_s     = 1'b0;
    if (start) begin
      word_nx_s    = word;
      reveal_nx_s  = prereveal(word);
      guessed_nx_s = 26'd0;
      wrong_nx_s   = 3'd0;
      idx_nx_s     = {IW{1'b0}};
      hit_nx_s     = 1'b0;
      state_nx_s   = PLAY;
    end else begin
      case (state_r)
        PLAY: begin
          if (guess_valid && guess_ready) begin
            if ((guess_letter > LAST_LETTER) || guessed_r[guess_letter]) begin
              dup_nx_s = 1'b1;
            end else begin
              guessed_nx_s[guess_letter] = 1'b1;
              letter_nx_s = guess_letter;
              hit_nx_s    = 1'b0;
              idx_nx_s    = {IW{1'b0}};
              state_nx_s  = SCAN;
            end
          end else begin
            state_nx_s = PLAY;
          end
        end
        SCAN: begin
          if (slot_of(word_r, idx_r) == letter_r) begin
            reveal_nx_s[idx_r] = 1'b1;
            hit_nx_s           = 1'b1;
          end else begin
            hit_nx_s = hit_r;
          end
          if (idx_r == LAST_IDX) begin
            state_nx_s = UPDATE;
          end else begin
            idx_nx_s = idx_r + IW'(1);
          end
        end
        UPDATE: begin
          wrong_nx_s = wrong_upd_s;
          if (&reveal_r) begin
            state_nx_s = WON;
          end else if (wrong_upd_s == WRONG_LIMIT) begin
            state_nx_s = LOST;
          end else begin
            state_nx_s = PLAY;
          end
        end
        IDLE, WON, LOST: begin
          state_nx_s = state_r;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State registers and registered outputs, all derived from next-state values
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      state_r     <= IDLE;
      word_r      <= {5*WORD_LEN{1'b0}};
      reveal_r    <= {WORD_LEN{1'b0}};
      guessed_r   <= 26'd0;
      idx_r       <= {IW{1'b0}};
      letter_r    <= 5'd0;
      hit_r       <= 1'b0;
      wrong_cnt   <= 3'd0;
      guess_ready <= 1'b0;
      guess_dup   <= 1'b0;
      game_won    <= 1'b0;
      game_lost   <= 1'b0;
      slot_code   <= {WORD_LEN{GLYPH_HIDE}};
    end else begin
      state_r     <= state_nx_s;
      word_r      <= word_nx_s;
      reveal_r    <= reveal_nx_s;
      guessed_r   <= guessed_nx_s;
      idx_r       <= idx_nx_s;
      letter_r    <= letter_nx_s;
      hit_r       <= hit_nx_s;
      wrong_cnt   <= wrong_nx_s;
      guess_ready <= (state_nx_s == PLAY);
      guess_dup   <= dup_nx_s;
      game_won    <= (state_nx_s == WON);
      game_lost   <= (state_nx_s == LOST);
      slot_code   <= glyphs(word_nx_s, reveal_nx_s, state_nx_s == LOST);
    end
  end

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Scoreboard bench for hangman_game_ctrl. The driver applies starts and guesses
// to a word-level game model and queues the expected response. A monitor pops
// from the queue whenever the DUT signals a result: a guess_dup pulse, a
// guess_ready rise, or a game_won or game_lost rise.
module tb_hangman_game_ctrl;

  localparam int WL = 10;
  localparam int MW = 6;

  logic            dclk;
  logic            clr_n;
  logic            start;
  logic [5*WL-1:0] word;
  logic            guess_valid;
  logic [4:0]      guess_letter;
  logic            guess_ready;
  logic            guess_dup;
  logic [5*WL-1:0] slot_code;
  logic [2:0]      wrong_cnt;
  logic            game_won;
  logic            game_lost;

  hangman_game_ctrl #(.WORD_LEN(WL), .MAX_WRONG(MW)) dut (
    .dclk(dclk), .clr_n(clr_n), .start(start), .word(word),
    .guess_valid(guess_valid), .guess_letter(guess_letter),
    .guess_ready(guess_ready), .guess_dup(guess_dup), .slot_code(slot_code),
    .wrong_cnt(wrong_cnt), .game_won(game_won), .game_lost(game_lost)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  typedef struct {
    bit              is_dup;
    logic [5*WL-1:0] slots;
    int              wrong;
    bit              won;
    bit              lost;
    int              low;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference game model, kept at word level
  int mw[WL];
  bit mrev[WL];
  bit mg[26];
  int mwrong;
  bit mwon, mlost;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [5*WL-1:0] pack_word();
    logic [5*WL-1:0] w;
    for (int i = 0; i < WL; i++) w[5*i +: 5] = 5'(mw[i]);
    return w;
  endfunction

  function automatic logic [5*WL-1:0] model_disp();
    logic [5*WL-1:0] d;
    for (int i = 0; i < WL; i++) begin
      if (mrev[i]) d[5*i +: 5] = 5'(mw[i]);
`ifdef HANGMAN_REVEAL_ON_LOSS_EN
      else if (mlost) d[5*i +: 5] = 5'(mw[i]);
`else
      else if (mlost) d[5*i +: 5] = 5'd27;
`endif
      else d[5*i +: 5] = 5'd26;
    end
    return d;
  endfunction

  task automatic model_start();
    for (int i = 0; i < WL; i++) mrev[i] = (mw[i] > 25);
    for (int i = 0; i < 26; i++) mg[i] = 1'b0;
    mwrong = 0; mwon = 1'b0; mlost = 1'b0;
  endtask

  task automatic model_guess(input int l, output exp_t e);
    bit hit, all;
    if (l > 25 || mg[l]) begin
      e.is_dup = 1'b1; e.low = -1;
    end else begin
      mg[l] = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < WL; i++) if (mw[i] == l) begin mrev[i] = 1'b1; hit = 1'b1; end
      if (!hit && mwrong < MW) mwrong++;
      all = 1'b1;
      for (int i = 0; i < WL; i++) if (!mrev[i]) all = 1'b0;
      mwon = all;
      mlost = !all && (mwrong == MW);
      e.is_dup = 1'b0; e.low = WL + 1;
    end
    e.slots = model_disp(); e.wrong = mwrong; e.won = mwon; e.lost = mlost;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(posedge dclk); #1; n++; end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  task automatic do_start(input bit push);
    exp_t e;
    word = pack_word();
    start = 1'b1;
    @(posedge dclk); #1;
    start = 1'b0;
    model_start();
    e.is_dup = 1'b0; e.slots = model_disp(); e.wrong = 0;
    e.won = 1'b0; e.lost = 1'b0; e.low = -1;
    if (push) q.push_back(e);
    wait_drain();
  endtask

  task automatic do_guess(input int l, input bit push);
    exp_t e;
    int n = 0;
    while (guess_ready !== 1'b1 && n < 50) begin @(posedge dclk); #1; n++; end
    if (guess_ready !== 1'b1) begin
      chk("ready_wait", 64'd0, 64'd1);
      return;
    end
    guess_valid = 1'b1; guess_letter = 5'(l);
    @(posedge dclk); #1;
    guess_valid = 1'b0;
    model_guess(l, e);
    if (push) q.push_back(e);
    wait_drain();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_slots"}, 64'(slot_code), 64'({WL{5'd26}}));
    chk({tag, "_wrong"}, 64'(wrong_cnt), 64'd0);
    chk({tag, "_ready"}, 64'(guess_ready), 64'd0);
    chk({tag, "_dup"},   64'(guess_dup), 64'd0);
    chk({tag, "_won"},   64'(game_won), 64'd0);
    chk({tag, "_lost"},  64'(game_lost), 64'd0);
  endtask

  // Monitor: detect DUT result events and compare against the queue head
  bit prev_ready = 1'b0, prev_won = 1'b0, prev_lost = 1'b0;
  int lowcnt = 0;
  always @(negedge dclk) begin
    bit rr, tr, dp;
    exp_t e;
    rr = (guess_ready === 1'b1) && !prev_ready;
    tr = ((game_won === 1'b1) && !prev_won) || ((game_lost === 1'b1) && !prev_lost);
    dp = (guess_dup === 1'b1);
    if (dp || rr || tr) begin
      if (q.size() == 0) begin
        chk("spurious_event", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("event_kind_dup", 64'(dp), 64'(e.is_dup));
        chk("slot_code", 64'(slot_code), 64'(e.slots));
        chk("wrong_cnt", 64'(wrong_cnt), 64'(e.wrong));
        chk("game_won", 64'(game_won), 64'(e.won));
        chk("game_lost", 64'(game_lost), 64'(e.lost));
        chk("guess_ready", 64'(guess_ready), 64'(!e.won && !e.lost));
        if (e.low >= 0) chk("ready_low_cycles", 64'(lowcnt), 64'(e.low));
      end
    end
    if (guess_ready === 1'b1) lowcnt = 0; else lowcnt++;
    prev_ready = (guess_ready === 1'b1);
    prev_won   = (game_won === 1'b1);
    prev_lost  = (game_lost === 1'b1);
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_word(input int w0, w1, w2, w3, w4, w5, w6, w7, w8, w9);
    mw[0] = w0; mw[1] = w1; mw[2] = w2; mw[3] = w3; mw[4] = w4;
    mw[5] = w5; mw[6] = w6; mw[7] = w7; mw[8] = w8; mw[9] = w9;
  endtask

  // Stimulus
  initial begin
    int win_seq[7];
    int miss_seq[6];
    int cnt;
    win_seq  = '{15, 17, 14, 6, 0, 12, 4};
    miss_seq = '{25, 24, 23, 22, 21, 20};
    clr_n = 1'b0; start = 1'b0; word = '0; guess_valid = 1'b0; guess_letter = 5'd0;
    for (int i = 0; i < WL; i++) mw[i] = 0;
    model_start();
    repeat (3) @(posedge dclk);
    #1 clr_n = 1'b1;
    repeat (5) @(posedge dclk);
    #1;
    check_reset_vals("reset");

    // PROGRAMMER: hit R, repeat R, then six misses
    set_word(15, 17, 14, 6, 17, 0, 12, 12, 4, 17);
    do_start(1'b1);
    do_guess(17, 1'b1);
    do_guess(17, 1'b1);
    do_guess(30, 1'b1);
    for (int i = 0; i < 6; i++) do_guess(miss_seq[i], 1'b1);

    // Fresh game, win with all distinct letters
    do_start(1'b1);
    for (int i = 0; i < 7; i++) do_guess(win_seq[i], 1'b1);

    // start in the middle of a scan, then the same letter is a fresh guess
    do_start(1'b1);
    do_guess(15, 1'b0);
    repeat (4) @(posedge dclk);
    #1;
    set_word(7, 0, 13, 6, 12, 0, 13, 15, 28, 4);
    do_start(1'b1);
    do_guess(15, 1'b1);
    do_guess(0, 1'b1);

    // Reset in the middle of a scan
    do_guess(13, 1'b0);
    repeat (3) @(posedge dclk);
    #1 clr_n = 1'b0;
    @(posedge dclk);
    #1;
    check_reset_vals("midscan_clr");
    clr_n = 1'b1;
    for (int i = 0; i < WL; i++) mw[i] = 0;
    model_start();
    repeat (2) @(posedge dclk);
    #1;

    // Random games
    for (int g = 0; g < 20; g++) begin
      for (int i = 0; i < WL; i++)
        mw[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(26, 31))
                                             : int'($urandom_range(0, 25));
      do_start(1'b1);
      cnt = 0;
      while (!mwon && !mlost && cnt < 200) begin
        do_guess(int'($urandom_range(0, 27)), 1'b1);
        cnt++;
      end
    end

    repeat (3) @(posedge dclk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
